// File: rtl/fp_mul_requester.sv
// Sends one operand pair to a strobe/ack floating-point multiplier and returns the product.
// If the multiplier stalls too long, it returns a quiet-NaN error response instead.
module fp_mul_requester #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      in_A,
  output logic [31:0]      in_B,
  output logic             strb_A,
  output logic             strb_B,
  input  logic             in_A_ack,
  input  logic             in_B_ack,
  input  logic [31:0]      output_prod,
  input  logic             output_prod_stb,
  output logic             out_prod_ack,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] rsp_cycles
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_PROD, ACK, RESP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [31:0]      ERR_NAN   = 32'h7FC0_0000;

  state_t           state_q, state_d;
  logic [31:0]      in_a_q, in_a_d, in_b_q, in_b_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             strb_a_q, strb_a_d, strb_b_q, strb_b_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rsp_cycles_q, rsp_cycles_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;

  always_comb begin
    state_d      = state_q;
    in_a_d       = in_a_q;
    in_b_d       = in_b_q;
    strb_a_d     = strb_a_q;
    strb_b_d     = strb_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;
    cnt_d        = cnt_q;
    timed_out    = (cnt_q == TIMEOUT_C);
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          in_a_d   = req_a;
          in_b_d   = req_b;
          strb_a_d = 1'b1;
          strb_b_d = 1'b1;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (strb_a_q && in_A_ack) strb_a_d = 1'b0;
        if (strb_b_q && in_B_ack) strb_b_d = 1'b0;
        // Timeout takes priority so the counter can never run past TIMEOUT unnoticed.
        if (timed_out) begin
          strb_a_d     = 1'b0;
          strb_b_d     = 1'b0;
          rsp_data_d   = ERR_NAN;
          rsp_err_d    = 1'b1;
          rsp_cycles_d = TIMEOUT_C;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (!strb_a_d && !strb_b_d) state_d = WAIT_PROD;
        end
      end
      WAIT_PROD: begin
        if (output_prod_stb) begin
          rsp_data_d   = output_prod;
          rsp_err_d    = 1'b0;
          rsp_cycles_d = cnt_q;
          state_d      = ACK;
        end else if (timed_out) begin
          rsp_data_d   = ERR_NAN;
          rsp_err_d    = 1'b1;
          rsp_cycles_d = TIMEOUT_C;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACK: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_a_q       <= '0;
      in_b_q       <= '0;
      strb_a_q     <= 1'b0;
      strb_b_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      strb_a_q     <= strb_a_d;
      strb_b_q     <= strb_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign out_prod_ack = (state_q == ACK);
  assign in_A         = in_a_q;
  assign in_B         = in_b_q;
  assign strb_A       = strb_a_q;
  assign strb_B       = strb_b_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_cycles   = rsp_cycles_q;

endmodule

// File: tb/tb_fp_mul_requester.sv
// Self-checking bench for fp_mul_requester: directed scenarios plus randomized transactions
// compared against a cycle-count model of the request/ack/product/timeout rules.
module tb_fp_mul_requester;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [31:0]      in_A, in_B;
  logic             strb_A, strb_B;
  logic             in_A_ack = 1'b0;
  logic             in_B_ack = 1'b0;
  logic [31:0]      output_prod = '0;
  logic             output_prod_stb = 1'b0;
  logic             out_prod_ack;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [CNT_W-1:0] rsp_cycles;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent transaction (cycle 0 = first cycle after accept edge).
  int               obs_rsp_cyc, obs_drop_a, obs_drop_b, obs_ack_cnt, obs_ack_cyc;
  int               obs_in_bad, obs_hold_bad;
  logic [31:0]      obs_data;
  logic             obs_err;
  logic [CNT_W-1:0] obs_cycles;
  logic             obs_consume_ready, obs_idle_ready, obs_idle_valid, obs_idle_strb;

  // Model expectations for the same transaction.
  int               exp_rsp_cyc, exp_drop_a, exp_drop_b, exp_ack_cnt, exp_ack_cyc;
  logic [31:0]      exp_data;
  logic             exp_err;
  logic [CNT_W-1:0] exp_cycles;

  fp_mul_requester #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .in_A(in_A), .in_B(in_B), .strb_A(strb_A), .strb_B(strb_B),
    .in_A_ack(in_A_ack), .in_B_ack(in_B_ack),
    .output_prod(output_prod), .output_prod_stb(output_prod_stb), .out_prod_ack(out_prod_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_cycles(rsp_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  // Strobes are high from cycle 0; an ack pulsed in cycle k is seen at the following edge.
  // Both acked -> WAIT_PROD from cycle max(ka,kb)+1; counter value equals cycle index.
  task automatic model_txn(input logic [31:0] prod, input int ka, input int kb, input int dp);
    int w, p;
    bit cap;
    w = ((ka > kb) ? ka : kb) + 1;
    p = (dp < 0) ? -1 : w + dp;
    cap = (w <= TIMEOUT) && (dp >= 0) && (p <= TIMEOUT);
    exp_drop_a = ((ka < TIMEOUT) ? ka : TIMEOUT) + 1;
    exp_drop_b = ((kb < TIMEOUT) ? kb : TIMEOUT) + 1;
    if (cap) begin
      exp_data = prod; exp_err = 1'b0; exp_cycles = CNT_W'(p);
      exp_ack_cnt = 1; exp_ack_cyc = p + 1; exp_rsp_cyc = p + 2;
    end else begin
      exp_data = 32'h7FC0_0000; exp_err = 1'b1; exp_cycles = CNT_W'(TIMEOUT);
      exp_ack_cnt = 0; exp_ack_cyc = -1; exp_rsp_cyc = TIMEOUT + 1;
    end
  endtask

  // Drives one transaction and records what the DUT did; starts and ends in an IDLE cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod,
                         input int ka, input int kb, input int dp, input int early,
                         input int hold, input bit spur);
    int w, p;
    w = ((ka > kb) ? ka : kb) + 1;
    p = (dp < 0) ? -1 : w + dp;
    obs_rsp_cyc = -1; obs_drop_a = -1; obs_drop_b = -1; obs_ack_cnt = 0; obs_ack_cyc = -1;
    obs_in_bad = 0; obs_hold_bad = 0;
    req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    for (int c = 0; c < TIMEOUT + 8 && obs_rsp_cyc < 0; c++) begin
      in_A_ack = (c == ka);
      in_B_ack = (c == kb);
      output_prod_stb = (c == p) || (c == early);
      output_prod = (c == p) ? prod : $urandom;
      @(negedge clk);
      if (strb_A !== 1'b1 && obs_drop_a < 0) obs_drop_a = c;
      if (strb_B !== 1'b1 && obs_drop_b < 0) obs_drop_b = c;
      if ((strb_A === 1'b1 && in_A !== a) || (strb_B === 1'b1 && in_B !== b)) obs_in_bad++;
      if (out_prod_ack === 1'b1) begin obs_ack_cnt++; obs_ack_cyc = c; end
      if (rsp_valid === 1'b1) begin
        obs_rsp_cyc = c; obs_data = rsp_data; obs_err = rsp_err; obs_cycles = rsp_cycles;
      end
      @(posedge clk); #1;
    end
    in_A_ack = 1'b0; in_B_ack = 1'b0; output_prod_stb = spur; output_prod = $urandom;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== obs_data || rsp_err !== obs_err ||
          rsp_cycles !== obs_cycles || req_ready !== 1'b0 || out_prod_ack !== 1'b0)
        obs_hold_bad++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    obs_consume_ready = req_ready;
    if (rsp_valid !== 1'b1 || rsp_data !== obs_data || out_prod_ack !== 1'b0) obs_hold_bad++;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0; output_prod_stb = 1'b0;
    @(negedge clk);
    obs_idle_ready = req_ready; obs_idle_valid = rsp_valid; obs_idle_strb = strb_A | strb_B;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({strb_A, strb_B, out_prod_ack, rsp_valid, rsp_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000",
               {strb_A, strb_B, out_prod_ack, rsp_valid, rsp_err});
    end
    checks++;
    if (in_A !== 32'h0 || in_B !== 32'h0 || rsp_data !== 32'h0 || rsp_cycles !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: in_A=%h in_B=%h rsp_data=%h rsp_cycles=%0d, expected all 0",
               in_A, in_B, rsp_data, rsp_cycles);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: req_ready=%b, expected 1", req_ready);
    end
  endtask

  task automatic test_basic();
    run_txn(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1, 1, 3, -1, 0, 1'b0);
    checks++;
    if (obs_data !== 32'h40C0_0000 || obs_err !== 1'b0 || obs_cycles !== 8'd5) begin
      errors++;
      $display("[TB] FAIL basic_rsp: data=%h err=%b cycles=%0d, expected 40c00000 0 5",
               obs_data, obs_err, obs_cycles);
    end
    checks++;
    if (obs_ack_cnt !== 1 || obs_ack_cyc !== 6 || obs_rsp_cyc !== 7) begin
      errors++;
      $display("[TB] FAIL basic_timing: acks=%0d ack_cyc=%0d rsp_cyc=%0d, expected 1 6 7",
               obs_ack_cnt, obs_ack_cyc, obs_rsp_cyc);
    end
  endtask

  task automatic test_staggered_acks();
    logic [31:0] pr;
    pr = $urandom;
    model_txn(pr, 2, 6, 2);
    run_txn($urandom, $urandom, pr, 2, 6, 2, -1, 0, 1'b0);
    checks++;
    if (obs_drop_a !== 3 || obs_drop_b !== 7) begin
      errors++;
      $display("[TB] FAIL stagger_strobes: drop_a=%0d drop_b=%0d, expected 3 7", obs_drop_a, obs_drop_b);
    end
    checks++;
    if (obs_cycles !== exp_cycles || obs_data !== exp_data || obs_in_bad !== 0) begin
      errors++;
      $display("[TB] FAIL stagger_rsp: cycles=%0d data=%h in_bad=%0d, expected %0d %h 0",
               obs_cycles, obs_data, obs_in_bad, exp_cycles, exp_data);
    end
  endtask

  task automatic test_timeout();
    for (int t = 0; t < 2; t++) begin
      run_txn($urandom, $urandom, $urandom, (t == 0) ? 0 : 3, (t == 0) ? 0 : 40, -1, -1, 0, 1'b0);
      checks++;
      if (obs_rsp_cyc !== TIMEOUT + 1 || obs_ack_cnt !== 0) begin
        errors++;
        $display("[TB] FAIL timeout_timing[%0d]: rsp_cyc=%0d acks=%0d, expected %0d 0",
                 t, obs_rsp_cyc, obs_ack_cnt, TIMEOUT + 1);
      end
      checks++;
      if (obs_data !== 32'h7FC0_0000 || obs_err !== 1'b1 || obs_cycles !== 8'd16 ||
          obs_idle_strb !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_rsp[%0d]: data=%h err=%b cycles=%0d, expected 7fc00000 1 16",
                 t, obs_data, obs_err, obs_cycles);
      end
    end
  endtask

  task automatic test_capture_boundary();
    logic [31:0] pr;
    pr = $urandom;
    run_txn($urandom, $urandom, pr, 1, 1, 14, -1, 0, 1'b0);
    checks++;
    if (obs_data !== pr || obs_err !== 1'b0 || obs_cycles !== 8'd16 || obs_ack_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL boundary_capture: data=%h err=%b cycles=%0d acks=%0d, expected %h 0 16 1",
               obs_data, obs_err, obs_cycles, obs_ack_cnt, pr);
    end
    run_txn($urandom, $urandom, pr, 1, 1, 15, -1, 0, 1'b0);
    checks++;
    if (obs_err !== 1'b1 || obs_ack_cnt !== 0 || obs_rsp_cyc !== TIMEOUT + 1) begin
      errors++;
      $display("[TB] FAIL boundary_late: err=%b acks=%0d rsp_cyc=%0d, expected 1 0 %0d",
               obs_err, obs_ack_cnt, obs_rsp_cyc, TIMEOUT + 1);
    end
  endtask

  task automatic test_backpressure();
    run_txn($urandom, $urandom, $urandom, 0, 1, 1, -1, 10, 1'b1);
    checks++;
    if (obs_hold_bad !== 0 || obs_consume_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: bad_cycles=%0d consume_ready=%b, expected 0 0",
               obs_hold_bad, obs_consume_ready);
    end
    checks++;
    if (obs_idle_ready !== 1'b1 || obs_idle_valid !== 1'b0 || obs_idle_strb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_release: ready=%b valid=%b strb=%b, expected 1 0 0",
               obs_idle_ready, obs_idle_valid, obs_idle_strb);
    end
  endtask

  task automatic test_early_prod();
    logic [31:0] pr;
    pr = $urandom;
    model_txn(pr, 1, 4, 2);
    run_txn($urandom, $urandom, pr, 1, 4, 2, 2, 0, 1'b0);
    checks++;
    if (obs_ack_cnt !== 1 || obs_ack_cyc !== exp_ack_cyc || obs_data !== pr ||
        obs_cycles !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL early_prod: acks=%0d ack_cyc=%0d data=%h cycles=%0d, expected 1 %0d %h %0d",
               obs_ack_cnt, obs_ack_cyc, obs_data, obs_cycles, exp_ack_cyc, pr, exp_cycles);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    req_a = 32'h3F80_0000; req_b = 32'hC000_0000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; in_A_ack = 1'b1; in_B_ack = 1'b1;
    @(posedge clk); #1;
    in_A_ack = 1'b0; in_B_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({strb_A, strb_B, out_prod_ack, rsp_valid, rsp_err, req_ready} !== 6'b000001 ||
        in_A !== 32'h0 || in_B !== 32'h0 || rsp_data !== 32'h0 || rsp_cycles !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: ctrl=%b in_A=%h in_B=%h data=%h cycles=%0d, expected 000001 0 0 0 0",
               {strb_A, strb_B, out_prod_ack, rsp_valid, rsp_err, req_ready},
               in_A, in_B, rsp_data, rsp_cycles);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; output_prod_stb = 1'b1; output_prod = $urandom;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_prod_ack !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    output_prod_stb = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL reset_abandon: %0d cycles showed ack/rsp after reset, expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pr;
    for (int i = 0; i < 3; i++) begin
      pr = $urandom;
      model_txn(pr, i, 0, i);
      run_txn($urandom, $urandom, pr, i, 0, i, -1, 0, 1'b0);
      checks++;
      if (obs_data !== exp_data || obs_rsp_cyc !== exp_rsp_cyc || obs_consume_ready !== 1'b0 ||
          obs_idle_strb !== 1'b0) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: data=%h rsp_cyc=%0d consume_ready=%b strb=%b, expected %h %0d 0 0",
                 i, obs_data, obs_rsp_cyc, obs_consume_ready, obs_idle_strb, exp_data, exp_rsp_cyc);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, pr;
    int ka, kb, dp, w, early;
    for (int n = 0; n < 30; n++) begin
      a = $urandom; b = $urandom; pr = $urandom;
      ka = $urandom_range(0, 10); kb = $urandom_range(0, 10);
      dp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 8));
      w = ((ka > kb) ? ka : kb) + 1;
      early = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, w - 1)) : -1;
      model_txn(pr, ka, kb, dp);
      run_txn(a, b, pr, ka, kb, dp, early, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_data !== exp_data || obs_err !== exp_err || obs_cycles !== exp_cycles) begin
        errors++;
        $display("[TB] FAIL rand_rsp[%0d]: data=%h err=%b cycles=%0d, expected %h %b %0d (ka=%0d kb=%0d dp=%0d)",
                 n, obs_data, obs_err, obs_cycles, exp_data, exp_err, exp_cycles, ka, kb, dp);
      end
      checks++;
      if (obs_rsp_cyc !== exp_rsp_cyc || obs_ack_cnt !== exp_ack_cnt || obs_ack_cyc !== exp_ack_cyc) begin
        errors++;
        $display("[TB] FAIL rand_timing[%0d]: rsp_cyc=%0d acks=%0d ack_cyc=%0d, expected %0d %0d %0d",
                 n, obs_rsp_cyc, obs_ack_cnt, obs_ack_cyc, exp_rsp_cyc, exp_ack_cnt, exp_ack_cyc);
      end
      checks++;
      if (obs_drop_a !== exp_drop_a || obs_drop_b !== exp_drop_b || obs_in_bad !== 0) begin
        errors++;
        $display("[TB] FAIL rand_strobes[%0d]: drop_a=%0d drop_b=%0d in_bad=%0d, expected %0d %0d 0",
                 n, obs_drop_a, obs_drop_b, obs_in_bad, exp_drop_a, exp_drop_b);
      end
      checks++;
      if (obs_hold_bad !== 0 || obs_consume_ready !== 1'b0 || obs_idle_ready !== 1'b1 ||
          obs_idle_valid !== 1'b0 || obs_idle_strb !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_handshake[%0d]: hold_bad=%0d consume_ready=%b idle=%b%b%b, expected 0 0 100",
                 n, obs_hold_bad, obs_consume_ready, obs_idle_ready, obs_idle_valid, obs_idle_strb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_staggered_acks();
    test_timeout();
    test_capture_boundary();
    test_backpressure();
    test_early_prod();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
